ysyx_24080006_axi_sram: RTL and testbench
=========================================

// Module: ysyx_24080006_axi_sram
// PURPOSE
//  AXI4 subordinate (responder) serving single-beat read/write transactions from the LSU/IFU masters out of a
//  word-organised on-chip SRAM. Sits behind the xbar on the SRAM window. One outstanding transaction at a time.
//  Programmable response latency models slow memory. Out-of-window accesses return DECERR.
// PARAMETERS
//  BASE_ADDR  32'h0f00_0000  byte address of word 0
//  DEPTH      2048           number of 32-bit words (power of 2); window = DEPTH*4 bytes
//  LATENCY    2              wait cycles from address(+data) acceptance to rvalid/bvalid (0..255)
// PORTS
//  clock            in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  arvalid/arready  in/out 1 AR handshake
//  araddr           in   32  read byte address
//  arid             in   4   read ID, echoed on rid
//  rvalid/rready    out/in 1 R handshake
//  rdata            out  32  full aligned word; master performs lane select/extension
//  rresp            out  2   2'b00 OKAY, 2'b11 DECERR
//  rid              out  4   captured arid
//  rlast            out  1   1 whenever rvalid (single beat)
//  awvalid/awready  in/out 1 AW handshake
//  awaddr           in   32  write byte address
//  awid             in   4   write ID, echoed on bid
//  wvalid/wready    in/out 1 W handshake
//  wdata            in   32  write data, already lane-aligned by master
//  wstrb            in   4   byte enables; wstrb[i] writes wdata[8i+7:8i]
//  bvalid/bready    out/in 1 B handshake
//  bresp            out  2   2'b00 OKAY, 2'b11 DECERR
//  bid              out  4   captured awid
// BEHAVIOUR
//  - Reset (async, active-high): state IDLE, counter 0; rvalid, bvalid, rlast 0; rdata, rresp, rid, bresp, bid 0.
//    SRAM contents are not reset. Reset mid-transaction aborts it silently; no response is issued.
//  - States: IDLE, WR_COLLECT, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP.
//  - Readies are combinational decodes of state and the registered aw_got/w_got flags:
//    awready = (IDLE|WR_COLLECT) & !aw_got; wready = (IDLE|WR_COLLECT) & !w_got;
//    arready = IDLE & !awvalid & !wvalid. Writes have priority over reads.
//  - IDLE: AW or W handshake captures addr/id or data/strb. Both in one cycle -> WR_WAIT.
//    Only one -> WR_COLLECT. arvalid&arready -> capture araddr/arid, go to RD_WAIT.
//  - WR_COLLECT: wait for the missing AW or W; both captured -> WR_WAIT. AW-before-W and W-before-AW are both legal.
//  - RD_WAIT/WR_WAIT: counter loads LATENCY on entry and decrements.
//    At 0: perform the array access, then go to RD_RESP/WR_RESP with rvalid/bvalid=1 on the next edge.
//    LATENCY=0 -> valid is asserted the cycle after the final handshake.
//  - Decode: hit = (addr - BASE_ADDR) < DEPTH*4 (32-bit unsigned subtract).
//    Index = (addr - BASE_ADDR)[$clog2(DEPTH)+1:2]; addr[1:0] ignored.
//    Miss -> resp 2'b11, rdata 0, no array write.
//  - Write: byte-masked by wstrb. wstrb=0 is OKAY with no change. awsize, arsize, burst fields and wlast are
//    not ports and are ignored; the LSU drives wlast 0.
//  - RD_RESP/WR_RESP: rvalid/bvalid and all payload held stable until rready/bready is sampled high.
//    Valid drops on the next edge, then go to IDLE. rready/bready high before valid is legal.
//    Valid is never withdrawn without a handshake.
//  - Simultaneous arvalid+awvalid in IDLE: write served first. AR stays pending and is accepted in IDLE after B completes.
//  - Throughput: at most 1 transaction per LATENCY+3 cycles. No outstanding-ID reordering.
// TESTING
//  1 AW+W same cycle: 0x0f00_0004, 0xDEADBEEF, strb 4'hF, awid 2; then AR same addr, arid 1.
//    -> bresp 00, bid 2; rdata 0xDEADBEEF, rresp 00, rid 1, rlast 1.
//  2 W 0x0000AB00 strb 4'b0010 to 0x0f00_0005, then read 0x0f00_0004.
//    -> rdata 0xDEADABEF. With LATENCY=2, rvalid rises exactly 3 cycles after the AR handshake.
//  3 W at cycle t, AW at t+4 (and reverse order) -> awready/wready each drop after their own handshake.
//    bvalid at t+4+LATENCY+1; data correct.
//  4 arvalid, awvalid and wvalid all high in IDLE -> arready 0 until the B handshake completes.
//    The following read returns the newly written word.
//  5 Hold rready/bready low 6 cycles -> rvalid/bvalid, rdata, rid, bid stable throughout; single handshake only.
//  6 Read/write 0x1000_0000 -> rresp/bresp 2'b11, rdata 0, SRAM unchanged.
//    Assert reset during RD_WAIT -> rvalid stays 0; arready 1 after release.

Source files
------------

// File: rtl/ysyx_24080006_axi_sram.sv
// AXI4 single-beat subordinate backed by a word-organised on-chip SRAM.
// One transaction in flight; programmable response latency; out-of-window accesses answer DECERR.
module ysyx_24080006_axi_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h0f00_0000,
    parameter int          DEPTH     = 2048,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  rid,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid
);

    localparam int          IDX_W  = $clog2(DEPTH);
    localparam logic [31:0] WINDOW = 32'(DEPTH * 4);

    typedef enum logic [2:0] {IDLE, WR_COLLECT, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP} state_t;

    state_t            state, state_next;
    logic              aw_got, w_got;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        wstrb_q, id_q;
    logic [7:0]        cnt;
    logic [31:0]       mem [DEPTH];

    logic              collecting, aw_hs, w_hs, ar_hs, access;
    logic [31:0]       offset;
    logic              hit;
    logic [IDX_W-1:0]  idx;

    assign collecting = (state == IDLE) || (state == WR_COLLECT);
    assign awready    = collecting && !aw_got;
    assign wready     = collecting && !w_got;
    assign arready    = (state == IDLE) && !awvalid && !wvalid;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign ar_hs      = arvalid && arready;

    // A single captured address serves both directions since only one transaction is ever open.
    assign offset = addr_q - BASE_ADDR;
    assign hit    = offset < WINDOW;
    assign idx    = offset[IDX_W+1:2];
    assign access = ((state == RD_WAIT) || (state == WR_WAIT)) && (cnt == 8'd0);

    assign rvalid = (state == RD_RESP);
    assign bvalid = (state == WR_RESP);
    assign rlast  = rvalid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_hs || w_hs)
                    state_next = (aw_hs && w_hs) ? WR_WAIT : WR_COLLECT;
                else if (ar_hs)
                    state_next = RD_WAIT;
            end
            WR_COLLECT: begin
                if ((aw_got || aw_hs) && (w_got || w_hs))
                    state_next = WR_WAIT;
            end
            RD_WAIT: if (cnt == 8'd0) state_next = RD_RESP;
            WR_WAIT: if (cnt == 8'd0) state_next = WR_RESP;
            RD_RESP: if (rready) state_next = IDLE;
            WR_RESP: if (bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            id_q    <= 4'd0;
            cnt     <= 8'd0;
            rdata   <= 32'd0;
            rresp   <= 2'b00;
            rid     <= 4'd0;
            bresp   <= 2'b00;
            bid     <= 4'd0;
        end else begin
            state <= state_next;
            if (aw_hs) begin
                addr_q <= awaddr;
                id_q   <= awid;
                aw_got <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                w_got   <= 1'b1;
            end
            if (ar_hs) begin
                addr_q <= araddr;
                id_q   <= arid;
            end
            if (state == WR_WAIT) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            // Counter reloads only on entry to a wait state, so LATENCY=0 still costs one cycle.
            if (((state_next == RD_WAIT) || (state_next == WR_WAIT)) && (state != state_next))
                cnt <= 8'(LATENCY);
            else if (((state == RD_WAIT) || (state == WR_WAIT)) && (cnt != 8'd0))
                cnt <= cnt - 8'd1;
            if (access && (state == RD_WAIT)) begin
                rdata <= hit ? mem[idx] : 32'd0;
                rresp <= hit ? 2'b00 : 2'b11;
                rid   <= id_q;
            end
            if (access && (state == WR_WAIT)) begin
                bresp <= hit ? 2'b00 : 2'b11;
                bid   <= id_q;
            end
        end
    end

    // SRAM contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (access && (state == WR_WAIT) && hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i])
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// Scoreboard bench for the AXI SRAM subordinate: drivers queue expected R/B beats,
// a negedge monitor pops and compares them whenever a handshake is about to happen.
module tb_ysyx_24080006_axi_sram;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = 32'd0;
    logic [3:0]  arid = 4'd0;
    logic        rvalid, rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = 32'd0;
    logic [3:0]  awid = 4'd0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    resp_t rd_q[$];
    resp_t wr_q[$];
    resp_t r_exp, b_exp;
    int    checks = 0;
    int    fails = 0;
    int    r_cnt = 0;
    int    b_cnt = 0;

    ysyx_24080006_axi_sram #(
        .BASE_ADDR(32'h0f00_0000),
        .DEPTH    (2048),
        .LATENCY  (LAT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arid   (arid),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rid    (rid),
        .rlast  (rlast),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .awid   (awid),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .bid    (bid)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a valid&ready pair seen at negedge completes on the next posedge.
    always @(negedge clock) begin
        if (!reset) begin
            if (rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    check_output("r_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    r_exp = rd_q.pop_front();
                    check_output("rdata", rdata, r_exp.data);
                    check_output("rresp", 32'(rresp), 32'(r_exp.resp));
                    check_output("rid", 32'(rid), 32'(r_exp.id));
                    check_output("rlast", 32'(rlast), 32'd1);
                end
                r_cnt++;
            end
            if (bvalid && bready) begin
                if (wr_q.size() == 0) begin
                    check_output("b_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    b_exp = wr_q.pop_front();
                    check_output("bresp", 32'(bresp), 32'(b_exp.resp));
                    check_output("bid", 32'(bid), 32'(b_exp.id));
                end
                b_cnt++;
            end
        end
    end

    task automatic apply_read(input logic [31:0] addr, input logic [3:0] id,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp, input int hold);
        int  start;
        int  k;
        int  n;
        bit  fired;
        rd_q.push_back('{exp_data, exp_resp, id});
        start = r_cnt;
        fired = 1'b0;
        k = 0;
        n = 0;
        rready = (hold == 0);
        araddr = addr;
        arid = id;
        arvalid = 1'b1;
        while (!fired && k < 50) begin
            @(negedge clock);
            fired = arvalid && arready;
            @(posedge clock); #1;
            k++;
        end
        arvalid = 1'b0;
        if (!fired) check_output("ar_timeout", 32'd0, 32'd1);
        while (!rvalid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check_output("r_latency", 32'(n), 32'(LAT + 1));
        for (int i = 0; i < hold; i++) begin
            check_output("r_hold_valid", 32'(rvalid), 32'd1);
            check_output("r_hold_data", rdata, exp_data);
            check_output("r_hold_id", 32'(rid), 32'(id));
            @(posedge clock); #1;
        end
        rready = 1'b1;
        k = 0;
        while (r_cnt == start && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        if (r_cnt == start) check_output("r_timeout", 32'd0, 32'd1);
        check_output("r_single", 32'(rvalid), 32'd0);
    endtask

    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic [3:0] id, input int aw_at, input int w_at,
                               input logic [1:0] exp_resp, input int hold);
        int  start;
        int  k;
        int  n;
        bit  aw_done;
        bit  w_done;
        bit  aw_fire;
        bit  w_fire;
        wr_q.push_back('{32'd0, exp_resp, id});
        start = b_cnt;
        aw_done = 1'b0;
        w_done = 1'b0;
        k = 0;
        n = 0;
        bready = (hold == 0);
        awaddr = addr;
        awid = id;
        wdata = data;
        wstrb = strb;
        while (!(aw_done && w_done) && k < 50) begin
            awvalid = !aw_done && (k >= aw_at);
            wvalid = !w_done && (k >= w_at);
            @(negedge clock);
            if (w_done && !aw_done) check_output("wready_dropped", 32'(wready), 32'd0);
            if (aw_done && !w_done) check_output("awready_dropped", 32'(awready), 32'd0);
            aw_fire = awvalid && awready;
            w_fire = wvalid && wready;
            @(posedge clock); #1;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            k++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (!(aw_done && w_done)) check_output("aw_w_timeout", 32'd0, 32'd1);
        while (!bvalid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check_output("b_latency", 32'(n), 32'(LAT + 1));
        for (int i = 0; i < hold; i++) begin
            check_output("b_hold_valid", 32'(bvalid), 32'd1);
            check_output("b_hold_id", 32'(bid), 32'(id));
            @(posedge clock); #1;
        end
        bready = 1'b1;
        k = 0;
        while (b_cnt == start && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        if (b_cnt == start) check_output("b_timeout", 32'd0, 32'd1);
        check_output("b_single", 32'(bvalid), 32'd0);
    endtask

    initial begin
        int  bstart;
        int  rstart;
        int  k;
        bit  fired;

        $display("[TB] start");
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_rvalid", 32'(rvalid), 32'd0);
        check_output("rst_bvalid", 32'(bvalid), 32'd0);
        check_output("rst_rlast", 32'(rlast), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        check_output("rst_ids", {24'd0, rid, bid}, 32'd0);
        check_output("rst_readies", {29'd0, arready, awready, wready}, 32'd7);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic full-word write then read
        apply_write(32'h0f00_0004, 32'hDEAD_BEEF, 4'hF, 4'd2, 0, 0, 2'b00, 0);
        apply_read(32'h0f00_0004, 4'd1, 32'hDEAD_BEEF, 2'b00, 0);

        // Byte-lane write, unaligned low address bits ignored
        apply_write(32'h0f00_0005, 32'h0000_AB00, 4'b0010, 4'd5, 0, 0, 2'b00, 0);
        apply_read(32'h0f00_0004, 4'd1, 32'hDEAD_ABEF, 2'b00, 0);
        apply_write(32'h0f00_0004, 32'hFFFF_FFFF, 4'h0, 4'd6, 0, 0, 2'b00, 0);
        apply_read(32'h0f00_0004, 4'd2, 32'hDEAD_ABEF, 2'b00, 0);

        // W before AW, then AW before W
        apply_write(32'h0f00_0008, 32'h1234_5678, 4'hF, 4'd3, 4, 0, 2'b00, 0);
        apply_read(32'h0f00_0008, 4'd4, 32'h1234_5678, 2'b00, 0);
        apply_write(32'h0f00_000C, 32'hCAFE_F00D, 4'hF, 4'd4, 0, 4, 2'b00, 0);
        apply_read(32'h0f00_000C, 4'd5, 32'hCAFE_F00D, 2'b00, 0);

        // AR, AW and W together: write first, AR held off until B completes
        wr_q.push_back('{32'd0, 2'b00, 4'd7});
        rd_q.push_back('{32'hA5A5_5A5A, 2'b00, 4'd3});
        bstart = b_cnt;
        rstart = r_cnt;
        awaddr = 32'h0f00_0010; awid = 4'd7;
        wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
        araddr = 32'h0f00_0010; arid = 4'd3;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clock);
        check_output("ar_blocked_by_write", 32'(arready), 32'd0);
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        fired = 1'b0;
        k = 0;
        while (!fired && k < 50) begin
            @(negedge clock);
            if (arready) begin
                check_output("ar_after_b", 32'(b_cnt - bstart), 32'd1);
                fired = 1'b1;
            end else if (b_cnt == bstart) begin
                check_output("ar_held_low", 32'(arready), 32'd0);
            end
            @(posedge clock); #1;
            k++;
        end
        arvalid = 1'b0;
        if (!fired) check_output("ar_pending_timeout", 32'd0, 32'd1);
        k = 0;
        while (r_cnt == rstart && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        if (r_cnt == rstart) check_output("r_pending_timeout", 32'd0, 32'd1);

        // Backpressure on R and B
        apply_read(32'h0f00_0010, 4'd8, 32'hA5A5_5A5A, 2'b00, 6);
        apply_write(32'h0f00_0014, 32'h0BAD_F00D, 4'hF, 4'd9, 0, 0, 2'b00, 6);
        apply_read(32'h0f00_0014, 4'd10, 32'h0BAD_F00D, 2'b00, 0);

        // Window boundaries and DECERR; 0x1000_0000 would alias word 0 if decode were index-only
        apply_write(32'h0f00_0000, 32'h1122_3344, 4'hF, 4'd1, 0, 0, 2'b00, 0);
        apply_write(32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 4'd2, 0, 0, 2'b11, 0);
        apply_read(32'h1000_0000, 4'd3, 32'd0, 2'b11, 0);
        apply_read(32'h0f00_0000, 4'd4, 32'h1122_3344, 2'b00, 0);
        apply_write(32'h0f00_1FFC, 32'h5566_7788, 4'hF, 4'd11, 0, 0, 2'b00, 0);
        apply_read(32'h0f00_1FFC, 4'd12, 32'h5566_7788, 2'b00, 0);
        apply_read(32'h0f00_2000, 4'd13, 32'd0, 2'b11, 0);
        apply_read(32'h0eff_fffc, 4'd14, 32'd0, 2'b11, 0);

        // Reset during RD_WAIT aborts silently
        araddr = 32'h0f00_0004; arid = 4'd15; arvalid = 1'b1;
        fired = 1'b0;
        k = 0;
        while (!fired && k < 50) begin
            @(negedge clock);
            fired = arready;
            @(posedge clock); #1;
            k++;
        end
        arvalid = 1'b0;
        if (!fired) check_output("ar_abort_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_rvalid_in_reset", 32'(rvalid), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_output("abort_rvalid_after", 32'(rvalid), 32'd0);
        end
        check_output("abort_arready", 32'(arready), 32'd1);

        check_output("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check_output("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
